recorder_sequencer: RTL

//  Control FSM for the audio record/playback path. Sequences one single-port sample BRAM:
//  - while record_in is held, writes incoming 8-bit samples at the audio sample strobe;
//  - on play, reads them back one per strobe and loops.

---
 rtl/recorder_pkg.sv | 13 +
 rtl/audio_valid_pipe.sv | 38 +++
 rtl/recorder_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/recorder_pkg.sv
// Shared types for the audio record/playback sequencer.
// The state encoding is visible on state_out, so its order is fixed.
package recorder_pkg;

    typedef enum logic [1:0] {
        REC_IDLE   = 2'd0,
        REC_RECORD = 2'd1,
        REC_PLAY   = 2'd2
    } rec_state_t;

    localparam int AUDIO_W = 8;

endpackage

// File: rtl/audio_valid_pipe.sv
// Valid-bit delay line that tracks BRAM reads in flight. Each stage is a register.
// A synchronous flush drops every pending read at once.
module audio_valid_pipe #(
    parameter int LAT = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic flush_in,
    input  logic valid_in,
    output logic valid_out
);

    logic stage_q [LAT];

    generate
        for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
            logic stage_d;
            if (gi == 0) begin : g_head
                assign stage_d = valid_in;
            end else begin : g_body
                assign stage_d = stage_q[gi-1];
            end

            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    stage_q[gi] <= 1'b0;
                end else if (flush_in) begin
                    stage_q[gi] <= 1'b0;
                end else begin
                    stage_q[gi] <= stage_d;
                end
            end
        end
    endgenerate

    assign valid_out = stage_q[LAT-1];

endmodule

// File: rtl/recorder_sequencer.sv
// Record/playback controller for a single-port sample BRAM: writes samples while
// record_in is held, replays them one per strobe, and delivers read data to the DAC stage.
module recorder_sequencer
    import recorder_pkg::*;
#(
    parameter int DEPTH    = 65536,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int DATA_W   = AUDIO_W,
    parameter int READ_LAT = 2,
    parameter bit LOOP     = 1'b1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              record_in,
    input  logic              play_in,
    input  logic              audio_valid_in,
    input  logic [DATA_W-1:0] audio_in,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic              mem_we_out,
    output logic [DATA_W-1:0] mem_din_out,
    input  logic [DATA_W-1:0] mem_dout_in,
    output logic [DATA_W-1:0] single_out,
    output logic              single_valid_out,
    output logic [ADDR_W:0]   length_out,
    output logic [1:0]        state_out,
    output logic              finish
);

    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_WR  = (ADDR_W+1)'(DEPTH - 1);

    rec_state_t        state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   length_q, length_d;
    logic              armed_q, armed_d;
    logic              rd_issue_q, rd_issue_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] single_q, single_d;
    logic              single_valid_q, single_valid_d;
    logic              finish_q, finish_d;

    logic rec_req;
    logic flush;
    logic pipe_valid;

    // armed_q blocks a held record_in from restarting a recording that just filled the BRAM.
    assign rec_req = record_in & armed_q;

    audio_valid_pipe #(
        .LAT (READ_LAT)
    ) u_valid_pipe (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .flush_in  (flush),
        .valid_in  (rd_issue_q),
        .valid_out (pipe_valid)
    );

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        length_d       = length_q;
        armed_d        = armed_q | ~record_in;
        rd_issue_d     = 1'b0;
        addr_d         = addr_q;
        we_d           = 1'b0;
        din_d          = din_q;
        single_d       = single_q;
        single_valid_d = 1'b0;
        finish_d       = 1'b0;
        flush          = 1'b0;

        case (state_q)
            REC_IDLE: begin
                if (rec_req) begin
                    state_d  = REC_RECORD;
                    wr_ptr_d = '0;
                    armed_d  = 1'b0;
                    flush    = 1'b1;
                end else if (play_in && (length_q != '0)) begin
                    state_d  = REC_PLAY;
                    rd_ptr_d = '0;
                end
            end

            REC_RECORD: begin
                if (!record_in) begin
                    state_d  = REC_IDLE;
                    length_d = wr_ptr_q;
                end else if (audio_valid_in) begin
                    we_d     = 1'b1;
                    addr_d   = wr_ptr_q[ADDR_W-1:0];
                    din_d    = audio_in;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (wr_ptr_q == LAST_WR) begin
                        state_d  = REC_IDLE;
                        length_d = FULL_LEN;
                        finish_d = 1'b1;
                    end
                end
            end

            REC_PLAY: begin
                if (rec_req) begin
                    state_d  = REC_RECORD;
                    wr_ptr_d = '0;
                    armed_d  = 1'b0;
                    flush    = 1'b1;
                end else if (play_in) begin
                    rd_ptr_d = '0;
                end else if (audio_valid_in) begin
                    addr_d     = rd_ptr_q[ADDR_W-1:0];
                    rd_issue_d = 1'b1;
                    if (rd_ptr_q == (length_q - PTR_ONE)) begin
                        rd_ptr_d = '0;
                        finish_d = 1'b1;
                        if (!LOOP) begin
                            state_d = REC_IDLE;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                    end
                end
            end

            default: begin
                state_d = REC_IDLE;
            end
        endcase

        // Read data keeps draining after a one-shot playback ends; only a record entry discards it.
        if (flush) begin
            single_d = '0;
        end else if (pipe_valid) begin
            single_d       = mem_dout_in;
            single_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= REC_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            length_q       <= '0;
            armed_q        <= 1'b1;
            rd_issue_q     <= 1'b0;
            addr_q         <= '0;
            we_q           <= 1'b0;
            din_q          <= '0;
            single_q       <= '0;
            single_valid_q <= 1'b0;
            finish_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            length_q       <= length_d;
            armed_q        <= armed_d;
            rd_issue_q     <= rd_issue_d;
            addr_q         <= addr_d;
            we_q           <= we_d;
            din_q          <= din_d;
            single_q       <= single_d;
            single_valid_q <= single_valid_d;
            finish_q       <= finish_d;
        end
    end

    assign mem_addr_out     = addr_q;
    assign mem_we_out       = we_q;
    assign mem_din_out      = din_q;
    assign single_out       = single_q;
    assign single_valid_out = single_valid_q;
    assign length_out       = length_q;
    assign state_out        = state_q;
    assign finish           = finish_q;

endmodule
